// File: rtl/cd_rx_pkg.sv
// cd_rx_pkg: shared state encoding, frame header offsets and helpers for the rx byte assembler
package cd_rx_pkg;
    typedef enum logic [2:0] {INIT = 3'b001, DATA = 3'b010, SKIP = 3'b100} rx_state_t;
    localparam int HDR_SRC = 0;
    localparam int HDR_DST = 1;
    localparam int HDR_LEN = 2;
    localparam int OVERHEAD = 5;
    localparam logic [7:0] BROADCAST = 8'hff;
    function automatic logic [7:0] sat8(input int n);
        return n > 255 ? 8'hff : n[7:0];
    endfunction
endpackage

// File: rtl/rx_bytes_mf_if.sv
// rx_bytes_mf_if: rx_des byte stream in, ping-pong RAM write port and handover out
interface rx_bytes_mf_if #(parameter int BUF_AW = 8);
    logic              des_bus_idle;
    logic [7:0]        des_data;
    logic [15:0]       des_crc_data;
    logic              des_data_clk;
    logic              des_force_wait_idle;
    logic [7:0]        wr_byte;
    logic [BUF_AW-1:0] wr_addr;
    logic              wr_clk;
    logic [7:0]        wr_flags;
    logic [BUF_AW:0]   rx_len;
    logic              switch;
    modport master(
        input  des_bus_idle, des_data, des_crc_data, des_data_clk,
        output des_force_wait_idle, wr_byte, wr_addr, wr_clk, wr_flags, rx_len, switch
    );
    modport slave(
        output des_bus_idle, des_data, des_crc_data, des_data_clk,
        input  des_force_wait_idle, wr_byte, wr_addr, wr_clk, wr_flags, rx_len, switch
    );
endinterface

// File: rtl/rx_bytes_mf_filter.sv
// rx_addr_filter: source/destination accept decision with a registered promiscuous flag
module rx_addr_filter
    import cd_rx_pkg::*;
#(
    parameter int MC_EN = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] addr,
    input  logic [7:0] filter,
    input  logic [7:0] filter_m,
    output logic       prom,
    output logic       src_drop,
    output logic       dst_ok
);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) prom <= 1'b0;
        else prom <= filter == BROADCAST;
    assign src_drop = addr == filter && !prom;
    assign dst_ok = addr == filter || addr == BROADCAST || prom ||
                    (MC_EN != 0 && filter_m != BROADCAST && addr == filter_m);
endmodule

// File: rtl/rx_bytes_mf.sv
// rx_bytes_mf: frame byte assembler with address filter, length guard and CRC-checked handover
module rx_bytes_mf
    import cd_rx_pkg::*;
#(
    parameter int BUF_AW = 8,
    parameter int MAX_LEN = 253,
    parameter int MC_EN = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   filter,
    input  logic [7:0]   filter_m,
    input  logic         user_crc,
    input  logic         not_drop,
    input  logic         abort,
    output logic         error,
    output logic         len_err,
    rx_bytes_mf_if.master bus
);
    localparam logic [BUF_AW:0] I_SRC = (BUF_AW+1)'(HDR_SRC);
    localparam logic [BUF_AW:0] I_DST = (BUF_AW+1)'(HDR_DST);
    localparam logic [BUF_AW:0] I_LEN = (BUF_AW+1)'(HDR_LEN);
    rx_state_t state, state_n;
    logic [BUF_AW:0] byte_cnt, cnt_n, rx_len_n;
    logic [7:0] data_len, len_n, flags_n;
    logic [BUF_AW-1:0] addr_n;
    logic wclk_n, err_n, lerr_n, sw_n, fwi_n;
    logic prom, src_drop, dst_ok, last, crc_ok;

    rx_addr_filter #(.MC_EN(MC_EN)) u_filter (
        .clk, .reset_n, .addr(bus.des_data), .filter, .filter_m, .prom, .src_drop, .dst_ok
    );

    assign bus.wr_byte = bus.des_data;
    assign last = int'(byte_cnt) == int'(data_len) + OVERHEAD - 1;
    assign crc_ok = bus.des_crc_data == 16'h0 || user_crc;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= INIT;
            byte_cnt <= '0;
            data_len <= '0;
            error <= 1'b0;
            len_err <= 1'b0;
            bus.des_force_wait_idle <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_clk <= 1'b0;
            bus.wr_flags <= '0;
            bus.rx_len <= '0;
            bus.switch <= 1'b0;
        end else begin
            state <= state_n;
            byte_cnt <= cnt_n;
            data_len <= len_n;
            error <= err_n;
            len_err <= lerr_n;
            bus.des_force_wait_idle <= fwi_n;
            bus.wr_addr <= addr_n;
            bus.wr_clk <= wclk_n;
            bus.wr_flags <= flags_n;
            bus.rx_len <= rx_len_n;
            bus.switch <= sw_n;
        end

    // Idle with nothing received keeps waiting in DATA; only a started frame is judged.
    always_comb begin
        state_n = state;
        cnt_n = byte_cnt;
        len_n = data_len;
        addr_n = bus.wr_addr;
        flags_n = bus.wr_flags;
        rx_len_n = bus.rx_len;
        {wclk_n, err_n, lerr_n, sw_n, fwi_n} = '0;
        if (abort) state_n = INIT;
        else if (state == INIT) begin
            cnt_n = '0;
            len_n = '0;
            fwi_n = !bus.des_bus_idle;
            state_n = DATA;
        end else if (state == SKIP) state_n = bus.des_bus_idle ? INIT : SKIP;
        else if (bus.des_bus_idle) begin
            if (|byte_cnt) begin
                state_n = INIT;
                err_n = int'(byte_cnt) >= 2 || prom;
                if (err_n && not_drop) begin
                    sw_n = 1'b1;
                    flags_n = sat8(int'(byte_cnt));
                    rx_len_n = byte_cnt;
                end
            end
        end else if (bus.des_data_clk) begin
            addr_n = byte_cnt[BUF_AW-1:0];
            wclk_n = !byte_cnt[BUF_AW];
            cnt_n = &byte_cnt ? byte_cnt : byte_cnt + 1'b1;
            if (byte_cnt == I_SRC) state_n = src_drop ? SKIP : DATA;
            else if (byte_cnt == I_DST) state_n = dst_ok ? DATA : SKIP;
            else if (byte_cnt == I_LEN) begin
                len_n = bus.des_data;
                lerr_n = int'(bus.des_data) > MAX_LEN;
                err_n = lerr_n;
                state_n = lerr_n ? SKIP : DATA;
            end else if (last) begin
                state_n = INIT;
                err_n = !crc_ok;
                if (crc_ok || not_drop) begin
                    sw_n = 1'b1;
                    flags_n = crc_ok ? 8'h00 : sat8(int'(byte_cnt) + 1);
                    rx_len_n = byte_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_bytes_mf.sv
// tb_rx_bytes_mf: frame-level vector table on two parametrisations plus timing/abort/reset sequences
module tb_rx_bytes_mf;
    logic clk = 1'b0, reset_n = 1'b0;
    logic [7:0] filter = 8'h05, filter_m = 8'hff, data = 8'h00;
    logic user_crc = 1'b0, not_drop = 1'b0, abort = 1'b0, idle = 1'b1, dclk = 1'b0;
    logic [15:0] crc = 16'h0;
    logic err_a, lerr_a, err_b, lerr_b;
    int checks = 0, errors = 0;

    rx_bytes_mf_if #(.BUF_AW(8)) ia();
    rx_bytes_mf_if #(.BUF_AW(5)) ib();
    assign ia.des_bus_idle = idle;
    assign ia.des_data = data;
    assign ia.des_crc_data = crc;
    assign ia.des_data_clk = dclk;
    assign ib.des_bus_idle = idle;
    assign ib.des_data = data;
    assign ib.des_crc_data = crc;
    assign ib.des_data_clk = dclk;

    rx_bytes_mf #(.BUF_AW(8), .MAX_LEN(253), .MC_EN(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .filter(filter), .filter_m(filter_m), .user_crc(user_crc),
        .not_drop(not_drop), .abort(abort), .error(err_a), .len_err(lerr_a), .bus(ia)
    );
    rx_bytes_mf #(.BUF_AW(5), .MAX_LEN(16), .MC_EN(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .filter(filter), .filter_m(filter_m), .user_crc(user_crc),
        .not_drop(not_drop), .abort(abort), .error(err_b), .len_err(lerr_b), .bus(ib)
    );

    always #5 clk = ~clk;

    int wr [2], sw [2], er [2], le [2], fw [2];
    logic [7:0] alog [2][4096];
    always @(negedge clk) begin
        if (ia.wr_clk) begin alog[0][wr[0] % 4096] = ia.wr_addr; wr[0]++; end
        if (ib.wr_clk) begin alog[1][wr[1] % 4096] = 8'(ib.wr_addr); wr[1]++; end
        sw[0] += int'(ia.switch);
        sw[1] += int'(ib.switch);
        er[0] += int'(err_a);
        er[1] += int'(err_b);
        le[0] += int'(lerr_a);
        le[1] += int'(lerr_b);
        fw[0] += int'(ia.des_force_wait_idle);
        fw[1] += int'(ib.des_force_wait_idle);
    end

    typedef struct {
        bit sel; logic [7:0] flt, fm; bit uc, nd; logic [7:0] src, dst, len; int n; bit bad;
        int e_wr; bit e_sw, e_err, e_lerr; logic [7:0] e_flags; int e_rxl;
    } vec_t;
    vec_t v [$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                        input int n, input bit bad);
        for (int i = 0; i < n; i++) begin
            data = i == 0 ? src : i == 1 ? dst : i == 2 ? len : 8'(160 + i);
            crc = i == int'(len) + 4 ? (bad ? 16'hbeef : 16'h0000) : 16'h1234;
            dclk = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic start(input logic [7:0] f, input logic [7:0] fm, input bit uc, input bit nd);
        @(negedge clk);
        filter = f; filter_m = fm; user_crc = uc; not_drop = nd; idle = 1'b1; dclk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input int k, input vec_t r);
        int s, w0, s0, e0, l0, f0, bad_i;
        start(r.flt, r.fm, r.uc, r.nd);
        s = int'(r.sel);
        w0 = wr[s]; s0 = sw[s]; e0 = er[s]; l0 = le[s]; f0 = fw[s];
        idle = 1'b0;
        @(negedge clk);
        send(r.src, r.dst, r.len, r.n, r.bad);
        dclk = 1'b0; idle = 1'b1;
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_wr_count", k), wr[s] - w0, r.e_wr);
        chk($sformatf("v%0d_switch", k), sw[s] - s0, int'(r.e_sw));
        chk($sformatf("v%0d_error", k), er[s] - e0, int'(r.e_err));
        chk($sformatf("v%0d_len_err", k), le[s] - l0, int'(r.e_lerr));
        chk($sformatf("v%0d_force_wait", k), fw[s] - f0, 0);
        bad_i = -1;
        for (int i = r.e_wr - 1; i >= 0; i--)
            if (int'(alog[s][(w0 + i) % 4096]) != i % (s == 1 ? 32 : 256)) bad_i = i;
        chk($sformatf("v%0d_first_bad_addr", k), bad_i, -1);
        if (r.e_sw) begin
            chk($sformatf("v%0d_wr_flags", k), int'(s == 1 ? ib.wr_flags : ia.wr_flags), int'(r.e_flags));
            chk($sformatf("v%0d_rx_len", k), s == 1 ? int'(ib.rx_len) : int'(ia.rx_len), r.e_rxl);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_pulses"}, int'({err_a, lerr_a, ia.switch, ia.wr_clk, ia.des_force_wait_idle}), 0);
        chk({nm, "_wr_addr"}, int'(ia.wr_addr), 0);
        chk({nm, "_wr_flags"}, int'(ia.wr_flags), 0);
        chk({nm, "_rx_len"}, int'(ia.rx_len), 0);
        chk({nm, "_b_outs"}, int'({err_b, lerr_b, ib.switch, ib.wr_clk, ib.des_force_wait_idle,
                                   ib.wr_addr, ib.wr_flags, ib.rx_len}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, e0, f0;
        //          sel flt    fm     uc nd src    dst    len    n    bad  wr   sw err lerr flags  rxl
        v.push_back('{0, 8'h05, 8'hff, 0, 0, 8'h01, 8'h05, 8'h02, 7,   0,   7,   1, 0, 0, 8'h00, 7});
        v.push_back('{0, 8'h05, 8'hff, 0, 0, 8'h01, 8'hff, 8'h00, 5,   0,   5,   1, 0, 0, 8'h00, 5});
        v.push_back('{0, 8'h05, 8'h80, 0, 0, 8'h01, 8'h80, 8'h01, 6,   0,   6,   1, 0, 0, 8'h00, 6});
        v.push_back('{1, 8'h05, 8'h80, 0, 0, 8'h01, 8'h80, 8'h01, 6,   0,   2,   0, 0, 0, 8'h00, 0});
        v.push_back('{0, 8'h05, 8'hff, 0, 0, 8'h01, 8'h07, 8'h00, 5,   0,   2,   0, 0, 0, 8'h00, 0});
        v.push_back('{0, 8'h05, 8'hff, 0, 0, 8'h05, 8'h05, 8'h00, 5,   0,   1,   0, 0, 0, 8'h00, 0});
        v.push_back('{0, 8'h05, 8'hff, 0, 1, 8'h01, 8'h05, 8'h00, 5,   1,   5,   1, 1, 0, 8'h05, 5});
        v.push_back('{0, 8'h05, 8'hff, 0, 0, 8'h01, 8'h05, 8'h00, 5,   1,   5,   0, 1, 0, 8'h00, 0});
        v.push_back('{0, 8'h05, 8'hff, 1, 0, 8'h01, 8'h05, 8'h00, 5,   1,   5,   1, 0, 0, 8'h00, 5});
        v.push_back('{1, 8'h05, 8'hff, 0, 0, 8'h01, 8'h05, 8'h20, 10,  0,   3,   0, 1, 1, 8'h00, 0});
        v.push_back('{1, 8'h05, 8'hff, 0, 0, 8'h01, 8'h05, 8'h03, 8,   0,   8,   1, 0, 0, 8'h00, 8});
        v.push_back('{0, 8'h05, 8'hff, 0, 1, 8'h01, 8'h05, 8'hfd, 258, 1,   256, 1, 1, 0, 8'hff, 258});
        v.push_back('{0, 8'h05, 8'hff, 0, 0, 8'h01, 8'h05, 8'hfe, 6,   0,   3,   0, 1, 1, 8'h00, 0});
        v.push_back('{0, 8'h05, 8'hff, 0, 1, 8'h01, 8'h05, 8'h05, 4,   0,   4,   1, 1, 0, 8'h04, 4});
        v.push_back('{0, 8'h05, 8'hff, 0, 1, 8'h01, 8'h05, 8'h05, 1,   0,   1,   0, 0, 0, 8'h00, 0});
        v.push_back('{0, 8'hff, 8'hff, 0, 0, 8'hff, 8'h33, 8'h00, 5,   0,   5,   1, 0, 0, 8'h00, 5});
        v.push_back('{0, 8'hff, 8'hff, 0, 1, 8'hff, 8'h33, 8'h05, 1,   0,   1,   1, 1, 0, 8'h01, 1});

        #12;
        chk_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        foreach (v[k]) run(k, v[k]);

        start(8'h05, 8'hff, 0, 0);
        idle = 1'b0;
        @(negedge clk);
        send(8'h01, 8'h05, 8'h00, 5, 0);
        chk("sw_latency", int'(ia.switch), 1);
        chk("err_latency", int'(err_a), 0);
        dclk = 1'b0; idle = 1'b1;
        @(negedge clk);
        chk("sw_one_cycle", int'(ia.switch), 0);
        repeat (2) @(negedge clk);

        start(8'h05, 8'hff, 0, 0);
        s0 = sw[1];
        idle = 1'b0;
        @(negedge clk);
        send(8'h01, 8'h05, 8'h20, 3, 0);
        chk("len_err_latency", int'(lerr_b), 1);
        chk("len_error_latency", int'(err_b), 1);
        data = 8'h11;
        @(negedge clk);
        chk("len_skip_no_write", int'(ib.wr_clk), 0);
        dclk = 1'b0; idle = 1'b1;
        repeat (3) @(negedge clk);
        chk("len_no_switch", sw[1] - s0, 0);

        start(8'h05, 8'hff, 0, 1);
        s0 = sw[0]; e0 = er[0]; f0 = fw[0];
        idle = 1'b0;
        @(negedge clk);
        send(8'h01, 8'h05, 8'h02, 3, 0);
        dclk = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        idle = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_force_wait", fw[0] - f0, 1);
        chk("abort_switch", sw[0] - s0, 0);
        chk("abort_error", er[0] - e0, 0);

        start(8'h05, 8'hff, 0, 0);
        idle = 1'b0;
        @(negedge clk);
        send(8'h01, 8'h05, 8'h02, 3, 0);
        chk("pre_reset_wr_clk", int'(ia.wr_clk), 1);
        #1 reset_n = 1'b0;
        #1 chk_zero("mid_reset");
        dclk = 1'b0; idle = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
